hilo_muldiv: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO result registers for the pipelined MIPS datapath. It sits in the EX stage beside the ALU and accepts MULT/MULTU/DIV/DIVU with a start/busy/done handshake. hi_o/lo_o feed the write-back MUX_2to1, which selects between the ALU result and HI/LO for MFHI/MFLO. The hazard unit stalls on busy_o.

---
 rtl/hilo_muldiv_if.sv | 24 ++
 rtl/hilo_muldiv.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and
// the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
   parameter int size = 32
);
   logic            start_i;
   logic [1:0]      op_i;
   logic [size-1:0] src1_i;
   logic [size-1:0] src2_i;
   logic            busy_o;
   logic            done_o;
   logic [size-1:0] hi_o;
   logic [size-1:0] lo_o;

   modport master (
      output start_i, op_i, src1_i, src2_i,
      input  busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, src1_i, src2_i,
      output busy_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// clock; results land in hi_o/lo_o on the final step together with a
// one-cycle done_o pulse.
// Build option: define HILO_MULDIV_DIV_EN to compile in the divider.
// Without it, DIV/DIVU requests are ignored and only MULT/MULTU exist.
module hilo_muldiv #(
   parameter int size = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   hilo_muldiv_if.slave  bus
);

   localparam int CW = $clog2(size + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(size);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic            done_q;
   logic [size-1:0] hi_q;
   logic [size-1:0] lo_q;
   logic            neg_res;   // operand signs differ
   logic [size:0]   acc_hi;    // product upper half / partial remainder
   logic [size-1:0] acc_lo;    // product lower half / dividend-quotient
   logic [size-1:0] opnd;      // multiplicand / divisor magnitude
`ifdef HILO_MULDIV_DIV_EN
   logic            is_div;
   logic            neg_rem;   // dividend was negative
   logic            div0;
   logic [size:0]   div_trial;
   logic            div_ge;
`endif

   logic            accept;
   logic            signed_op;
   logic            a_neg;
   logic            b_neg;
   logic [size-1:0] a_mag;
   logic [size-1:0] b_mag;
   logic [size:0]     mul_sum;
   logic [2*size-1:0] mul_prod;
   logic [2*size-1:0] mul_fix;
   logic [size:0]     step_hi;
   logic [size-1:0]   step_lo;
   logic [size-1:0]   fin_hi;
   logic [size-1:0]   fin_lo;

   function automatic logic [size-1:0] cond_neg(input logic [size-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*size-1:0] cond_neg_wide(input logic [2*size-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.hi_o   = hi_q;
   assign bus.lo_o   = lo_q;

   // Requests are taken only outside RUN; divide requests need the divider.
`ifdef HILO_MULDIV_DIV_EN
   assign accept = bus.start_i && (state != RUN);
`else
   assign accept = bus.start_i && (state != RUN) && !bus.op_i[1];
`endif

   // Operand magnitudes and signs captured at accept time.
   always_comb begin
      signed_op = ~bus.op_i[0];
      a_neg     = signed_op & bus.src1_i[size-1];
      b_neg     = signed_op & bus.src2_i[size-1];
      a_mag     = cond_neg(bus.src1_i, a_neg);
      b_mag     = cond_neg(bus.src2_i, b_neg);
   end

   // One iteration step plus the sign-fixed result used on the final step.
   always_comb begin
      mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
      mul_prod = {mul_sum, acc_lo[size-1:1]};
      step_hi  = {1'b0, mul_prod[2*size-1:size]};
      step_lo  = mul_prod[size-1:0];
      mul_fix  = cond_neg_wide(mul_prod, neg_res);
      fin_hi   = mul_fix[2*size-1:size];
      fin_lo   = mul_fix[size-1:0];
`ifdef HILO_MULDIV_DIV_EN
      div_trial = {acc_hi[size-1:0], acc_lo[size-1]};
      div_ge    = div_trial >= {1'b0, opnd};
      if (is_div) begin
         step_hi = div_ge ? div_trial - {1'b0, opnd} : div_trial;
         step_lo = {acc_lo[size-2:0], div_ge};
         // Divide by zero naturally leaves |dividend| as remainder; after the
         // dividend-sign fixup that is the raw src1 bits.
         fin_lo  = div0 ? '1 : cond_neg(step_lo, neg_res);
         fin_hi  = cond_neg(step_hi[size-1:0], neg_rem);
      end
`endif
   end

   // Control FSM, iteration datapath and HI/LO result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_res <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
`ifdef HILO_MULDIV_DIV_EN
         is_div  <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (accept) begin
                  state   <= RUN;
                  busy_q  <= 1'b1;
                  cnt     <= CNT_INIT;
                  neg_res <= a_neg ^ b_neg;
                  acc_hi  <= '0;
                  acc_lo  <= b_mag;
                  opnd    <= a_mag;
`ifdef HILO_MULDIV_DIV_EN
                  is_div  <= bus.op_i[1];
                  neg_rem <= a_neg;
                  div0    <= (bus.src2_i == '0);
                  if (bus.op_i[1]) begin
                     acc_lo <= a_mag;
                     opnd   <= b_mag;
                  end
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  hi_q   <= fin_hi;
                  lo_q   <= fin_lo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed cases with hand-computed results plus
// randomized operations, all compared every cycle against a behavioural
// model built on plain 64-bit arithmetic.
module tb_hilo_muldiv;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hilo_muldiv_if #(.size(W)) bus ();

   hilo_muldiv #(.size(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation: {hi, lo}.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sp;
      int sa, sb;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
         end
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic bit legal(input logic [1:0] op);
`ifdef HILO_MULDIV_DIV_EN
      return 1'b1;
`else
      return !op[1];
`endif
   endfunction

   // Behavioural model: an accepted request produces its result W cycles later.
   logic        m_busy, m_done;
   logic [31:0] m_hi, m_lo;
   int          m_left;
   logic [63:0] m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_done <= 1'b0;
         if (m_left == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
         if (bus.start_i && legal(bus.op_i)) begin
            m_pend <= ref_result(bus.op_i, bus.src1_i, bus.src2_i);
            m_left <= W;
            m_busy <= 1'b1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy_o", 64'(bus.busy_o), 64'(m_busy));
         check("done_o", 64'(bus.done_o), 64'(m_done));
         check("hi_o",   64'(bus.hi_o),   64'(m_hi));
         check("lo_o",   64'(bus.lo_o),   64'(m_lo));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request (caller is at a negedge) and wait for done_o.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit got);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.src1_i  = a;
      bus.src2_i  = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      cyc = 0;
      while (!bus.done_o && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      got = bus.done_o;
   endtask

   task automatic run_lit(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
      int cyc;
      bit got;
      do_op(op, a, b, cyc, got);
      check({name, "_done"}, 64'(got), 64'(1));
      check({name, "_latency"}, 64'(cyc), 64'(W));
      check({name, "_hilo"}, {bus.hi_o, bus.lo_o}, exp);
   endtask

   logic [31:0] pool [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h10};

   initial begin
      int cyc;
      bit got;
      bit saw;
      logic [31:0] hold_hi, hold_lo;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      bus.start_i = 1'b0;
      bus.op_i    = 2'b00;
      bus.src1_i  = '0;
      bus.src2_i  = '0;

      // Model pins against hand-computed values.
      check("ref_multu_max", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      check("ref_mult_m3x5", ref_result(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
      check("ref_mult_minsq", ref_result(2'b00, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
      check("ref_divu_100_7", ref_result(2'b11, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
      check("ref_div_m7_2", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      check("ref_divu_by0", ref_result(2'b11, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);
      check("ref_div_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      check("rst_busy", 64'(bus.busy_o), 64'(0));
      check("rst_done", 64'(bus.done_o), 64'(0));
      check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // Directed multiplies, issued back-to-back from the DONE cycle.
      run_lit("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_lit("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_lit("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

`ifdef HILO_MULDIV_DIV_EN
      run_lit("divu_100_7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
      run_lit("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      run_lit("divu_by0", 2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
      run_lit("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
`else
      // Divide request without the divider: nothing may happen.
      @(negedge clk);
      hold_hi = bus.hi_o;
      hold_lo = bus.lo_o;
      bus.start_i = 1'b1;
      bus.op_i    = 2'b11;
      bus.src1_i  = 32'd9;
      bus.src2_i  = 32'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy_o || bus.done_o) saw = 1'b1;
         @(negedge clk);
      end
      check("nodiv_idle", 64'(saw), 64'(0));
      check("nodiv_hold", {bus.hi_o, bus.lo_o}, {hold_hi, hold_lo});
`endif

      // start pulsed during RUN is ignored.
      bus.start_i = 1'b1;
      bus.op_i    = 2'b01;
      bus.src1_i  = 32'd1234;
      bus.src2_i  = 32'd5678;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 2'b00;
      bus.src1_i  = 32'd99;
      bus.src2_i  = 32'd77;
      @(negedge clk);
      bus.start_i = 1'b0;
      cyc = 6;
      while (!bus.done_o && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("ignore_latency", 64'(cyc), 64'(W));
      check("ignore_hilo", {bus.hi_o, bus.lo_o}, 64'd7006652);
      @(negedge clk);
      check("ignore_no_rerun", 64'(bus.busy_o), 64'(0));

      // Reset in the middle of an operation.
      bus.start_i = 1'b1;
      bus.op_i    = 2'b01;
      bus.src1_i  = 32'hDEAD_BEEF;
      bus.src2_i  = 32'h1234_5678;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 64'(bus.busy_o), 64'(0));
      check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
      run_lit("multu_6x7", 2'b01, 32'd6, 32'd7, 64'd42);

      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      rst = 1'b1;
      bus.start_i = 1'b1;
      bus.op_i    = 2'b01;
      bus.src1_i  = 32'd3;
      bus.src2_i  = 32'd3;
      @(negedge clk);
      rst = 1'b0;
      bus.start_i = 1'b0;
      check("rst_start_busy", 64'(bus.busy_o), 64'(0));
      @(negedge clk);
      check("rst_start_busy2", 64'(bus.busy_o), 64'(0));

      // Randomized operations with random gaps.
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
         rb  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
         if (legal(rop)) begin
            do_op(rop, ra, rb, cyc, got);
            check("rand_done", 64'(got), 64'(1));
            check("rand_hilo", {bus.hi_o, bus.lo_o}, ref_result(rop, ra, rb));
         end else begin
            bus.start_i = 1'b1;
            bus.op_i    = rop;
            bus.src1_i  = ra;
            bus.src2_i  = rb;
            @(negedge clk);
            bus.start_i = 1'b0;
            repeat (3) @(negedge clk);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
